// File: rtl/load_store_unit_if.sv
// Core/memory port bundle for the load/store unit: request handshake from the MEM stage
// plus the single-cycle word-addressed data-memory bus.
interface load_store_unit_if #(
  parameter int size   = 32,
  parameter int length = 256
);
  localparam int AW = $clog2(length);

  logic            req;
  logic            ready;
  logic            isStore;
  logic [1:0]      sizeSel;
  logic            unsignedLoad;
  logic [AW+1:0]   byteAddr;
  logic [size-1:0] storeData;
  logic            done;
  logic            err;
  logic [size-1:0] loadData;

  logic            memRead;
  logic            memWrite;
  logic [AW-1:0]   memAddress;
  logic [size-1:0] memWriteData;
  logic [size-1:0] memReadData;

  // The load/store unit itself: answers core requests, drives the memory bus
  modport slave (
    input  req, isStore, sizeSel, unsignedLoad, byteAddr, storeData, memReadData,
    output ready, done, err, loadData, memRead, memWrite, memAddress, memWriteData
  );

  modport master (
    output req, isStore, sizeSel, unsignedLoad, byteAddr, storeData, memReadData,
    input  ready, done, err, loadData, memRead, memWrite, memAddress, memWriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// MIPS lb/lbu/lh/lhu/lw/sb/sh/sw engine for a word-addressed, combinational-read memory.
// Big-endian byte lanes; sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int size   = 32,
  parameter int length = 256
) (
  input logic clk,
  input logic rst_n,
  load_store_unit_if.slave bus
);

  localparam int AW = $clog2(length);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } stateType;

  stateType        state, nextState;

  logic            capStore;
  logic            capUnsigned;
  logic [1:0]      capSize;
  logic [1:0]      capOffset;
  logic [size-1:0] capData;
  logic            capture;

  logic            memReadQ, nextMemRead;
  logic            memWriteQ, nextMemWrite;
  logic [AW-1:0]   memAddressQ, nextMemAddress;
  logic [size-1:0] memWriteDataQ, nextMemWriteData;
  logic            doneQ, nextDone;
  logic            errQ, nextErr;
  logic [size-1:0] loadDataQ, nextLoadData;

  logic            reqBad;
  logic [7:0]      laneByte;
  logic [15:0]     laneHalf;
  logic [4:0]      laneShift;
  logic [size-1:0] laneMask;
  logic [size-1:0] loadValue;
  logic [size-1:0] mergedWord;

  assign bus.ready        = (state == IDLE);
  assign bus.memRead      = memReadQ;
  assign bus.memWrite     = memWriteQ;
  assign bus.memAddress   = memAddressQ;
  assign bus.memWriteData = memWriteDataQ;
  assign bus.done         = doneQ;
  assign bus.err          = errQ;
  assign bus.loadData     = loadDataQ;

  always_comb begin
    reqBad = 1'b0;
    case (bus.sizeSel)
      SIZE_BYTE: reqBad = 1'b0;
      SIZE_HALF: reqBad = bus.byteAddr[0];
      SIZE_WORD: reqBad = (bus.byteAddr[1:0] != 2'b00);
      default:   reqBad = 1'b1;
    endcase
  end

  // Lane k of a big-endian word sits at bits [31-8k -: 8]; halves at offset 0 or 2.
  always_comb begin
    laneByte = bus.memReadData[31:24];
    case (capOffset)
      2'd0:    laneByte = bus.memReadData[31:24];
      2'd1:    laneByte = bus.memReadData[23:16];
      2'd2:    laneByte = bus.memReadData[15:8];
      default: laneByte = bus.memReadData[7:0];
    endcase
    laneHalf = capOffset[1] ? bus.memReadData[15:0] : bus.memReadData[31:16];
  end

  always_comb begin
    loadValue = bus.memReadData;
    case (capSize)
      SIZE_BYTE: loadValue = {{(size-8){~capUnsigned & laneByte[7]}}, laneByte};
      SIZE_HALF: loadValue = {{(size-16){~capUnsigned & laneHalf[15]}}, laneHalf};
      default:   loadValue = bus.memReadData;
    endcase
  end

  // Merge for sb/sh: only the addressed lane is replaced, the rest of the word passes through.
  always_comb begin
    laneShift = 5'd0;
    laneMask  = size'(32'h0000_FFFF);
    if (capSize == SIZE_BYTE) begin
      laneShift = {~capOffset, 3'b000};
      laneMask  = size'(32'h0000_00FF) << laneShift;
    end else begin
      laneShift = capOffset[1] ? 5'd0 : 5'd16;
      laneMask  = size'(32'h0000_FFFF) << laneShift;
    end
    mergedWord = (bus.memReadData & ~laneMask) | ((capData << laneShift) & laneMask);
  end

  always_comb begin
    nextState        = state;
    capture          = 1'b0;
    nextMemRead      = 1'b0;
    nextMemWrite     = 1'b0;
    nextMemAddress   = memAddressQ;
    nextMemWriteData = memWriteDataQ;
    nextDone         = 1'b0;
    nextErr          = 1'b0;
    nextLoadData     = loadDataQ;
    case (state)
      IDLE: begin
        if (bus.req) begin
          capture = 1'b1;
          if (reqBad) begin
            nextState    = RESP;
            nextDone     = 1'b1;
            nextErr      = 1'b1;
            nextLoadData = '0;
          end else if (bus.isStore && bus.sizeSel == SIZE_WORD) begin
            nextState        = WR;
            nextMemWrite     = 1'b1;
            nextMemAddress   = bus.byteAddr[AW+1:2];
            nextMemWriteData = bus.storeData;
          end else begin
            nextState      = RD;
            nextMemRead    = 1'b1;
            nextMemAddress = bus.byteAddr[AW+1:2];
          end
        end
      end
      RD: begin
        if (capStore) begin
          nextState        = WR;
          nextMemWrite     = 1'b1;
          nextMemWriteData = mergedWord;
        end else begin
          nextState    = RESP;
          nextDone     = 1'b1;
          nextLoadData = loadValue;
        end
      end
      WR: begin
        nextState = RESP;
        nextDone  = 1'b1;
      end
      RESP: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Every bus/response output is a flop, so reset kills a pending write strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memReadQ      <= 1'b0;
      memWriteQ     <= 1'b0;
      memAddressQ   <= '0;
      memWriteDataQ <= '0;
      doneQ         <= 1'b0;
      errQ          <= 1'b0;
      loadDataQ     <= '0;
    end else begin
      memReadQ      <= nextMemRead;
      memWriteQ     <= nextMemWrite;
      memAddressQ   <= nextMemAddress;
      memWriteDataQ <= nextMemWriteData;
      doneQ         <= nextDone;
      errQ          <= nextErr;
      loadDataQ     <= nextLoadData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capStore    <= 1'b0;
      capUnsigned <= 1'b0;
      capSize     <= 2'b00;
      capOffset   <= 2'b00;
      capData     <= '0;
    end else if (capture) begin
      capStore    <= bus.isStore;
      capUnsigned <= bus.unsignedLoad;
      capSize     <= bus.sizeSel;
      capOffset   <= bus.byteAddr[1:0];
      capData     <= bus.storeData;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a reference memory model predicts each response
// into a scoreboard, which is popped and compared when the unit signals done.
module tb_load_store_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  load_store_unit_if #(.size(32), .length(256)) bus();

  load_store_unit #(.size(32), .length(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        err;
    logic        isLoad;
    logic [31:0] loadData;
    int          latency;
    int          reads;
    int          writes;
    logic [7:0]  wordIdx;
    logic [31:0] writeData;
  } expectType;

  expectType   scoreboard[$];
  logic [31:0] mem    [256] = '{default: 32'h0};
  logic [31:0] refMem [256] = '{default: 32'h0};
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign bus.memReadData = mem[bus.memAddress];

  always @(posedge clk) begin
    if (bus.memWrite) mem[bus.memAddress] <= bus.memWriteData;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: big-endian lanes via part-selects, updates refMem for legal stores.
  task automatic predict(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [9:0] addr, input logic [31:0] data, output expectType e);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          k;
    k = int'(addr[1:0]);
    w = refMem[addr[9:2]];
    e.err       = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    e.isLoad    = !st;
    e.loadData  = 32'h0;
    e.reads     = 0;
    e.writes    = 0;
    e.wordIdx   = addr[9:2];
    e.writeData = 32'h0;
    if (e.err) begin
      e.latency = 1;
    end else if (!st) begin
      e.latency = 2;
      e.reads   = 1;
      if (sz == 2'b00) begin
        b = w[31-8*k -: 8];
        e.loadData = uns ? {24'h0, b} : {{24{b[7]}}, b};
      end else if (sz == 2'b01) begin
        h = (k == 0) ? w[31:16] : w[15:0];
        e.loadData = uns ? {16'h0, h} : {{16{h[15]}}, h};
      end else begin
        e.loadData = w;
      end
    end else begin
      e.writes = 1;
      if (sz == 2'b10) begin
        e.latency = 2;
        w = data;
      end else begin
        e.latency = 3;
        e.reads   = 1;
        if (sz == 2'b00) w[31-8*k -: 8] = data[7:0];
        else if (k == 0) w[31:16] = data[15:0];
        else w[15:0] = data[15:0];
      end
      e.writeData = w;
      refMem[addr[9:2]] = w;
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after done.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic uns,
                               input logic [9:0] addr, input logic [31:0] data, input bit holdReq);
    expectType   e;
    expectType   got;
    int          waits, n, reads, writes;
    logic        both, seen;
    logic [7:0]  rAddr, wAddr;
    logic [31:0] wData;
    predict(st, sz, uns, addr, data, e);
    scoreboard.push_back(e);
    bus.isStore      = st;
    bus.sizeSel      = sz;
    bus.unsignedLoad = uns;
    bus.byteAddr     = addr;
    bus.storeData    = data;
    bus.req          = 1'b1;
    waits = 0;
    while (!bus.ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("readyBeforeAccept", 32'(bus.ready), 32'd1);
    if (holdReq) checkOutput("heldReqWait", waits, 0);
    @(posedge clk);
    @(negedge clk);
    if (!holdReq) bus.req = 1'b0;
    bus.isStore      = 1'($urandom_range(0, 1));
    bus.sizeSel      = 2'($urandom_range(0, 3));
    bus.unsignedLoad = 1'($urandom_range(0, 1));
    bus.byteAddr     = 10'($urandom);
    bus.storeData    = $urandom;
    n = 1; reads = 0; writes = 0; both = 1'b0; seen = 1'b0;
    rAddr = 8'h0; wAddr = 8'h0; wData = 32'h0;
    while (1) begin
      if (bus.memRead && bus.memWrite) both = 1'b1;
      if (bus.memRead) begin
        reads++;
        rAddr = bus.memAddress;
      end
      if (bus.memWrite) begin
        writes++;
        wAddr = bus.memAddress;
        wData = bus.memWriteData;
      end
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (n >= 8) break;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput("doneSeen", 32'(seen), 32'd1);
    got = scoreboard.pop_front();
    checkOutput("latency", n, got.latency);
    checkOutput("err", 32'(bus.err), 32'(got.err));
    if (got.isLoad || got.err) checkOutput("loadData", bus.loadData, got.loadData);
    checkOutput("readCycles", reads, got.reads);
    checkOutput("writeCycles", writes, got.writes);
    checkOutput("strobeExclusive", 32'(both), 32'd0);
    if (got.reads > 0) checkOutput("readAddr", 32'(rAddr), 32'(got.wordIdx));
    if (got.writes > 0) begin
      checkOutput("writeAddr", 32'(wAddr), 32'(got.wordIdx));
      checkOutput("writeData", wData, got.writeData);
    end
    checkOutput("memWord", mem[got.wordIdx], refMem[got.wordIdx]);
    @(negedge clk);
    checkOutput("donePulse", 32'(bus.done), 32'd0);
    checkOutput("readyAfterResp", 32'(bus.ready), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Ready"}, 32'(bus.ready), 32'd1);
    checkOutput({tag, "Done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "Err"}, 32'(bus.err), 32'd0);
    checkOutput({tag, "MemRead"}, 32'(bus.memRead), 32'd0);
    checkOutput({tag, "MemWrite"}, 32'(bus.memWrite), 32'd0);
    checkOutput({tag, "MemAddress"}, 32'(bus.memAddress), 32'd0);
  endtask

  initial begin
    bus.req          = 1'b0;
    bus.isStore      = 1'b0;
    bus.sizeSel      = 2'b00;
    bus.unsignedLoad = 1'b0;
    bus.byteAddr     = 10'h0;
    bus.storeData    = 32'h0;

    #1 rst_n = 1'b0;
    #2;
    $display("[TB] reset state");
    checkResetOutputs("reset");
    checkOutput("resetLoadData", bus.loadData, 32'h0);
    checkOutput("resetWriteData", bus.memWriteData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] word store and loads");
    applyStimulus(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 10'h011, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 10'h011, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 10'h010, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 10'h010, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 10'h013, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1, 10'h012, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 1'b0);

    $display("[TB] sub-word stores");
    applyStimulus(1'b1, 2'b01, 1'b0, 10'h012, 32'h00001234, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 10'h010, 32'h00000055, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 10'h013, 32'hAABBCC77, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);

    $display("[TB] illegal accesses");
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h013, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 10'h011, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 10'h010, 32'h0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 10'h011, 32'hFFFFFFFF, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 10'h012, 32'h12345678, 1'b0);

    $display("[TB] reset during read-modify-write");
    bus.isStore      = 1'b1;
    bus.sizeSel      = 2'b01;
    bus.unsignedLoad = 1'b0;
    bus.byteAddr     = 10'h016;
    bus.storeData    = 32'h0000CAFE;
    bus.req          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    checkOutput("abortInRead", 32'(bus.memRead), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    @(posedge clk);
    @(negedge clk);
    checkOutput("resetHeldMemWrite", 32'(bus.memWrite), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("postAbortMemWrite", 32'(bus.memWrite), 32'd0);
    end
    checkOutput("abortWordKept", mem[5], refMem[5]);
    checkOutput("abortReady", 32'(bus.ready), 32'd1);

    $display("[TB] back-to-back with req held");
    applyStimulus(1'b1, 2'b10, 1'b0, 10'h018, 32'h01020304, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h018, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h014, 32'h0, 1'b1);
    bus.req = 1'b0;
    @(negedge clk);

    $display("[TB] random mix");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    10'(10'h020 + 10'($urandom_range(0, 15))), $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
